alu_pe_credit_sched: RTL and testbench
======================================

// Module: alu_pe_credit_sched
// PURPOSE
//  Per-ALU-block issue scheduler in front of the PE switch. Takes each ALU request with its decoded PE select
//  (INT / MULDIV / DOT8), holds it in a 1-entry output stage, and caps the requests outstanding per PE
//  with credit counters. Also supports a drain/halt handshake so the block can be quiesced safely.
// PARAMETERS
//  PE_COUNT    3   number of PEs behind the switch (INT=0, MULDIV=1, DOT8=2)
//  CREDITS     4   max in-flight requests per PE (>=1)
//  DATAW       64  request payload width, passed through unmodified
//  PERF_W      32  perf counter width (used only with ALU_SCHED_PERF_EN)
//  derived: SELW=UP(CLOG2(PE_COUNT)), CNTW=CLOG2(CREDITS+1)
// PORTS
//  clk             in   1            clock, all state updates on rising edge
//  reset           in   1            synchronous, active-low (reset==0 clears state on next edge)
//  in_valid        in   1            request valid
//  in_pe_sel       in   SELW         target PE of request
//  in_data         in   DATAW        request payload
//  in_ready        out  1            request accepted when in_valid&&in_ready
//  out_valid       out  1            request to PE switch valid
//  out_pe_sel      out  SELW         registered PE select
//  out_data        out  DATAW        registered payload
//  out_ready       in   1            PE switch accepts
//  rsp_fire        in   PE_COUNT     one-hot-per-PE result handshake (credit return)
//  drain_req       in   1            request quiesce
//  drained         out  1            no request buffered or outstanding, issue halted
//  credit_zero     out  PE_COUNT     bit p = PE p has no credit left
//  perf_issued     out  PERF_W       requests sent to switch
//  perf_stalls     out  PERF_W       cycles in_valid held off due to credit exhaustion
// BEHAVIOUR
//  Reset: out_valid=0, out_pe_sel=0, out_data=0, all counters=0, FSM=RUN, drained=0, perf=0, in_ready=0 during reset.
//  Output stage: 1-entry pipeline reg, latency 1 cycle in->out; loads when in fire; clears when out fires and no load.
//  in_ready = (state==RUN) && (!out_valid || out_ready) && (cnt[in_pe_sel] < CREDITS). Depends on in_pe_sel
//   combinationally; in_valid never depends on in_ready.
//  Credits reserved at input acceptance: cnt[sel]++ on in fire; cnt[p]-- on rsp_fire[p].
//   Simultaneous inc+dec on same PE -> unchanged. rsp_fire[p] with cnt[p]==0 -> ignored, simulation assertion fires.
//   in_pe_sel >= PE_COUNT -> in_ready=0, assertion fires.
//  out_valid held until out_ready; out_pe_sel/out_data stable while out_valid&&!out_ready.
//  credit_zero[p] = (cnt[p]==CREDITS), registered-state derived, no input dependency.
//  FSM:
//   RUN   : normal issue; drain_req=1 -> DRAIN (in_ready forced 0 from the same cycle drain_req is seen).
//   DRAIN : no acceptance; buffered entry still forwarded; when !out_valid && all cnt==0 -> HALT.
//           drain_req dropped in DRAIN -> RUN.
//   HALT  : drained=1, in_ready=0; drain_req=0 -> RUN (drained=0 next cycle).
//  drain_req with nothing outstanding: RUN->DRAIN->HALT, drained=1 two cycles after drain_req sampled.
//  Reset mid-operation: in-flight credits forgotten; PEs must be reset in the same cycle.
// CONFIGURATION
//  ALU_SCHED_PERF_EN defined: perf_issued += 1 per out fire; perf_stalls += 1 per cycle with in_valid &&
//   state==RUN && cnt[in_pe_sel]==CREDITS; both wrap modulo 2^PERF_W, cleared by reset.
//  ALU_SCHED_PERF_EN undefined: perf_issued/perf_stalls tied to 0, no counter flops.
// TESTING
//  1 Back-to-back 8 INT reqs, out_ready=1, rsp_fire[0] 3 cycles after each issue -> each out 1 cycle after in, no stalls.
//  2 5 DOT8 reqs, no rsp -> 4 accepted, in_ready=0 on 5th, credit_zero=3'b100; one rsp_fire[2] -> 5th accepted next cycle.
//  3 cnt[1]=CREDITS, same-cycle in fire for sel=1 blocked; rsp_fire[1] + in fire for sel=1 next cycle -> cnt stays 4.
//  4 out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_pe_sel stable, in_ready=0, no counter change.
//  5 2 MULDIV outstanding, drain_req=1 -> in_ready=0, drained=1 one cycle after 2nd rsp_fire[1]; drain_req=0 -> RUN.
//  6 PERF_EN: 10 issues + 6 credit-stall cycles -> perf_issued=10, perf_stalls=6; without macro both read 0.

Source files
------------

// File: rtl/alu_pe_credit_sched_if.sv
// Request bus between the ALU block, the credit scheduler and the PE switch.
interface alu_pe_credit_sched_if #(
  parameter int SELW  = 2,
  parameter int DATAW = 64
);
  logic             valid;
  logic             ready;
  logic [SELW-1:0]  pe_sel;
  logic [DATAW-1:0] data;

  modport master (output valid, output pe_sel, output data, input  ready);
  modport slave  (input  valid, input  pe_sel, input  data, output ready);
endinterface

// File: rtl/alu_pe_credit_sched.sv
// Per-ALU-block issue scheduler: 1-entry output stage, per-PE credit caps, drain/halt handshake.
// Optional perf counters enabled by defining ALU_SCHED_PERF_EN.
module alu_pe_credit_sched #(
  parameter  int PE_COUNT = 3,
  parameter  int CREDITS  = 4,
  parameter  int DATAW    = 64,
  parameter  int PERF_W   = 32,
  localparam int SELW     = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1,
  localparam int CNTW     = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_pe_credit_sched_if.slave  in_if,
  alu_pe_credit_sched_if.master out_if,
  input  logic [PE_COUNT-1:0]   rsp_fire_i,
  input  logic                  drain_req_i,
  output logic                  drained_o,
  output logic [PE_COUNT-1:0]   credit_zero_o,
  output logic [PERF_W-1:0]     perf_issued_o,
  output logic [PERF_W-1:0]     perf_stalls_o
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q [PE_COUNT];
  logic [CNTW-1:0]  cnt_d [PE_COUNT];
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic [DATAW-1:0] out_data_q, out_data_d;

  logic             sel_ok, sel_full, in_ready, in_fire, out_fire, all_idle;
  logic [CNTW-1:0]  sel_cnt;
  logic [PE_COUNT-1:0] cnt_empty;

  always_comb begin
    sel_ok  = {1'b0, in_if.pe_sel} < (SELW + 1)'(PE_COUNT);
    sel_cnt = '0;
    for (int unsigned p = 0; p < PE_COUNT; p++) begin
      if (in_if.pe_sel == SELW'(p)) sel_cnt = cnt_q[p];
    end
    sel_full = (sel_cnt == CNTW'(CREDITS));
    // drain_req gates acceptance combinationally so nothing slips in on the cycle it rises
    in_ready = reset && (state_q == RUN) && !drain_req_i &&
               (!out_valid_q || out_if.ready) && sel_ok && !sel_full;
    in_fire  = in_if.valid && in_ready;
    out_fire = out_valid_q && out_if.ready;
  end

  always_comb begin
    all_idle = 1'b1;
    for (int unsigned p = 0; p < PE_COUNT; p++) begin
      cnt_empty[p]     = (cnt_q[p] == '0);
      credit_zero_o[p] = (cnt_q[p] == CNTW'(CREDITS));
      if (!cnt_empty[p]) all_idle = 1'b0;
      cnt_d[p] = cnt_q[p];
      // credit return on an empty counter is dropped
      if ((in_fire && in_if.pe_sel == SELW'(p)) && !(rsp_fire_i[p] && !cnt_empty[p]))
        cnt_d[p] = cnt_q[p] + 1'b1;
      else if (!(in_fire && in_if.pe_sel == SELW'(p)) && rsp_fire_i[p] && !cnt_empty[p])
        cnt_d[p] = cnt_q[p] - 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    out_data_d  = out_data_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_sel_d   = in_if.pe_sel;
      out_data_d  = in_if.data;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (drain_req_i) state_d = DRAIN;
      DRAIN:   if (!drain_req_i) state_d = RUN;
               else if (!out_valid_q && all_idle) state_d = HALT;
      HALT:    if (!drain_req_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      out_data_q  <= '0;
      for (int unsigned p = 0; p < PE_COUNT; p++) cnt_q[p] <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_data_q  <= out_data_d;
      for (int unsigned p = 0; p < PE_COUNT; p++) cnt_q[p] <= cnt_d[p];
    end
  end

  assign in_if.ready   = in_ready;
  assign out_if.valid  = out_valid_q;
  assign out_if.pe_sel = out_sel_q;
  assign out_if.data   = out_data_q;
  assign drained_o     = (state_q == HALT);

`ifdef ALU_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_issued_q, perf_stalls_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_issued_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (out_fire) perf_issued_q <= perf_issued_q + 1'b1;
      if (in_if.valid && state_q == RUN && sel_ok && sel_full)
        perf_stalls_q <= perf_stalls_q + 1'b1;
    end
  end

  assign perf_issued_o = perf_issued_q;
  assign perf_stalls_o = perf_stalls_q;
`else
  assign perf_issued_o = '0;
  assign perf_stalls_o = '0;
`endif

  a_sel_range: assert property (@(posedge clk) disable iff (!reset) !(in_if.valid && !sel_ok));
  a_rsp_underflow: assert property (@(posedge clk) disable iff (!reset) (rsp_fire_i & cnt_empty) == '0);

endmodule

// File: tb/tb_alu_pe_credit_sched.sv
// Bench for alu_pe_credit_sched: directed scenarios plus random traffic against a queue/count model.
module tb_alu_pe_credit_sched;
  localparam int NPE  = 3;
  localparam int CRED = 4;

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_HALT  = 2;

  typedef struct {
    logic [1:0]  sel;
    logic [63:0] data;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  rsp_fire = '0;
  logic        drain_req = 1'b0;
  logic        drained;
  logic [2:0]  credit_zero;
  logic [31:0] perf_issued, perf_stalls;

  alu_pe_credit_sched_if #(.SELW(2), .DATAW(64)) in_if ();
  alu_pe_credit_sched_if #(.SELW(2), .DATAW(64)) out_if ();

  alu_pe_credit_sched #(.PE_COUNT(NPE), .CREDITS(CRED), .DATAW(64), .PERF_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_if         (in_if),
    .out_if        (out_if),
    .rsp_fire_i    (rsp_fire),
    .drain_req_i   (drain_req),
    .drained_o     (drained),
    .credit_zero_o (credit_zero),
    .perf_issued_o (perf_issued),
    .perf_stalls_o (perf_stalls)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  // Reference model: pending stage as a queue, outstanding requests per PE, quiesce mode
  req_t stage[$];
  int   outst[NPE];
  int   mode = M_RUN;
  int unsigned m_issued = 0;
  int unsigned m_stalls = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    if (!reset || mode != M_RUN || drain_req) return 1'b0;
    if (stage.size() != 0 && !out_if.ready) return 1'b0;
    if (in_if.pe_sel >= 2'(NPE)) return 1'b0;
    return outst[in_if.pe_sel] < CRED;
  endfunction

  task automatic model_step();
    bit inf, outf, idle;
    int nm;
    if (!reset) begin
      stage.delete();
      for (int p = 0; p < NPE; p++) outst[p] = 0;
      mode = M_RUN;
      m_issued = 0;
      m_stalls = 0;
      return;
    end
    inf  = in_if.valid && exp_ready();
    outf = (stage.size() != 0) && out_if.ready;
    idle = (stage.size() == 0);
    for (int p = 0; p < NPE; p++) if (outst[p] != 0) idle = 1'b0;
    nm = mode;
    if (mode == M_RUN && drain_req) nm = M_DRAIN;
    else if (mode == M_DRAIN && !drain_req) nm = M_RUN;
    else if (mode == M_DRAIN && idle) nm = M_HALT;
    else if (mode == M_HALT && !drain_req) nm = M_RUN;
    if (in_if.valid && mode == M_RUN && in_if.pe_sel < 2'(NPE) && outst[in_if.pe_sel] == CRED)
      m_stalls++;
    if (outf) begin
      m_issued++;
      void'(stage.pop_front());
    end
    for (int p = 0; p < NPE; p++) if (rsp_fire[p] && outst[p] > 0) outst[p]--;
    if (inf) begin
      stage.push_back('{sel: in_if.pe_sel, data: in_if.data});
      outst[in_if.pe_sel]++;
    end
    mode = nm;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [2:0] ez;
      for (int p = 0; p < NPE; p++) ez[p] = (outst[p] == CRED);
      check("in_ready", {63'd0, in_if.ready}, {63'd0, exp_ready()});
      check("out_valid", {63'd0, out_if.valid}, {63'd0, stage.size() != 0});
      if (stage.size() != 0) begin
        check("out_pe_sel", {62'd0, out_if.pe_sel}, {62'd0, stage[0].sel});
        check("out_data", out_if.data, stage[0].data);
      end
      check("credit_zero", {61'd0, credit_zero}, {61'd0, ez});
      check("drained", {63'd0, drained}, {63'd0, mode == M_HALT});
`ifdef ALU_SCHED_PERF_EN
      check("perf_issued", {32'd0, perf_issued}, {32'd0, m_issued});
      check("perf_stalls", {32'd0, perf_stalls}, {32'd0, m_stalls});
`else
      check("perf_issued", {32'd0, perf_issued}, 64'd0);
      check("perf_stalls", {32'd0, perf_stalls}, 64'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [63:0] d,
                       input bit ordy, input logic [2:0] rsp, input bit drn);
    in_if.valid  = v;
    in_if.pe_sel = s;
    in_if.data   = d;
    out_if.ready = ordy;
    rsp_fire     = rsp;
    drain_req    = drn;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    tick();
    tick();
    chk_en = 1'b1;

    // reset state, with a request offered while reset is still low
    drive(1, 0, 64'h55, 1, 0, 0);
    #3;
    check("rst_in_ready", {63'd0, in_if.ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_if.valid}, 64'd0);
    check("rst_out_data", out_if.data, 64'd0);
    check("rst_out_sel", {62'd0, out_if.pe_sel}, 64'd0);
    check("rst_credit_zero", {61'd0, credit_zero}, 64'd0);
    check("rst_drained", {63'd0, drained}, 64'd0);
    tick();
    reset = 1'b1;

    // back-to-back INT requests with credits returned shortly after
    for (int i = 0; i < 11; i++) begin
      drive(i < 8, 0, 64'h100 + 64'(i), 1, {2'b00, (i >= 3)}, 0);
      #3;
      if (i < 8) check("t1_in_ready", {63'd0, in_if.ready}, 64'd1);
      tick();
    end

    // DOT8 credit exhaustion and return
    for (int i = 0; i < 5; i++) begin
      drive(1, 2, 64'h200 + 64'(i), 1, 0, 0);
      #3;
      if (i < 4) check("t2_in_ready", {63'd0, in_if.ready}, 64'd1);
      else begin
        check("t2_blocked", {63'd0, in_if.ready}, 64'd0);
        check("t2_credit_zero", {61'd0, credit_zero}, 64'b100);
      end
      tick();
    end
    drive(1, 2, 64'h204, 1, 3'b100, 0); tick();
    drive(1, 2, 64'h204, 1, 0, 0);
    #3;
    check("t2_after_rsp", {63'd0, in_if.ready}, 64'd1);
    tick();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 1, 3'b100, 0); tick(); end

    // MULDIV full, then simultaneous return + accept
    for (int i = 0; i < 4; i++) begin drive(1, 1, 64'h300 + 64'(i), 1, 0, 0); tick(); end
    drive(1, 1, 64'h304, 1, 3'b010, 0);
    #3;
    check("t3_blocked", {63'd0, in_if.ready}, 64'd0);
    tick();
    drive(1, 1, 64'h304, 1, 3'b010, 0); tick();
    drive(1, 1, 64'h305, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0);
    #3;
    check("t3_credit_zero", {61'd0, credit_zero}, 64'b010);
    tick();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 1, 3'b010, 0); tick(); end

    // output back-pressure holds the stage
    drive(1, 0, 64'hDEAD_BEEF_0123_4567, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 64'h400 + 64'(i), 0, 0, 0);
      #3;
      check("t4_in_ready", {63'd0, in_if.ready}, 64'd0);
      check("t4_hold_data", out_if.data, 64'hDEAD_BEEF_0123_4567);
      tick();
    end
    drive(0, 0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 3'b001, 0); tick();

    // drain with two MULDIV outstanding
    drive(1, 1, 64'h500, 1, 0, 0); tick();
    drive(1, 1, 64'h501, 1, 0, 0); tick();
    drive(1, 0, 64'h502, 1, 0, 1);
    #3;
    check("t5_drain_gate", {63'd0, in_if.ready}, 64'd0);
    tick();
    drive(0, 0, 0, 1, 3'b010, 1); tick();
    drive(0, 0, 0, 1, 3'b010, 1); tick();
    drive(0, 0, 0, 1, 0, 1); tick();
    drive(0, 0, 0, 1, 0, 1);
    #3;
    check("t5_drained", {63'd0, drained}, 64'd1);
    tick();
    drive(1, 0, 64'h503, 1, 0, 0); tick();
    drive(1, 0, 64'h503, 1, 0, 0);
    #3;
    check("t5_resume_drained", {63'd0, drained}, 64'd0);
    check("t5_resume_ready", {63'd0, in_if.ready}, 64'd1);
    tick();

    // perf: 10 issues and 6 credit-stall cycles from a clean reset
    do_reset();
    for (int i = 0; i < 4; i++) begin drive(1, 2, 64'h600 + 64'(i), 1, 0, 0); tick(); end
    for (int i = 0; i < 6; i++) begin drive(1, 2, 64'h6FF, 1, 0, 0); tick(); end
    for (int i = 0; i < 6; i++) begin drive(1, (i < 4) ? 2'd0 : 2'd1, 64'h610 + 64'(i), 1, 0, 0); tick(); end
    drive(0, 0, 0, 1, 0, 0); tick();
    #3;
`ifdef ALU_SCHED_PERF_EN
    check("t6_issued", {32'd0, perf_issued}, 64'd10);
    check("t6_stalls", {32'd0, perf_stalls}, 64'd6);
`else
    check("t6_issued_off", {32'd0, perf_issued}, 64'd0);
    check("t6_stalls_off", {32'd0, perf_stalls}, 64'd0);
`endif
    tick();

    // random traffic with a mid-run reset
    begin
      bit drn = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        logic [2:0] rsp;
        for (int p = 0; p < NPE; p++) rsp[p] = (outst[p] > 0) && ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 39) == 0) drn = !drn;
        drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 2)), {$urandom, $urandom},
              $urandom_range(0, 3) != 0, rsp, drn);
        reset = !(i == 2000 || i == 2001);
        tick();
      end
      reset = 1'b1;
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
